// File: rtl/mau_pwm_seq.sv
// Sequences one point-wise multiply job through the MAU: it streams operand pairs from memory
// into the MAU, holds the MAU configuration for the whole job and writes the results back in order.
//
// state | meaning
// IDLE  | waiting for start; configuration holds the last job's selection
// ISSUE | one operand read per cycle, addresses 0..N_COEF-1
// DRAIN | all reads issued; collecting the remaining MAU results
// DONE  | one-cycle completion pulse, then back to IDLE
module mau_pwm_seq #(
  parameter int N_COEF = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              kd_sel,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data_a,
  input  logic [23:0]       rd_data_b,
  output logic [23:0]       mau_a,
  output logic [23:0]       mau_b,
  output logic              mau_enable,
  output logic              mau_kd_sel,
  output logic [3:0]        mau_alu_mode,
  output logic [23:0]       mau_q,
  output logic [24:0]       mau_barret_m,
  output logic [4:0]        mau_mm_N,
  input  logic              mau_valid,
  input  logic [23:0]       mau_o0,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data
);

  // One spare bit so N_COEF = 2^ADDR_W is reachable without wrapping.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_COEF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_COEF);

  localparam logic [23:0] KY_Q = 24'd3329;
  localparam logic [24:0] KY_M = 25'd5039;
  localparam logic [4:0]  KY_N = 5'd12;
  localparam logic [23:0] DI_Q = 24'd8380417;
  localparam logic [24:0] DI_M = 25'd8396807;
  localparam logic [4:0]  DI_N = 5'd23;
  localparam logic [3:0]  ALU_PWM = 4'b0100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic             last_write;

  // Results are taken the same cycle they arrive, but never beyond the job length.
  assign wr_en      = busy & mau_valid & (wr_cnt != CNT_FULL);
  assign wr_addr    = wr_en ? wr_cnt[ADDR_W-1:0] : '0;
  assign wr_data    = wr_en ? mau_o0 : '0;
  assign last_write = wr_en & (wr_cnt == CNT_LAST);

  assign rd_addr    = rd_en ? rd_cnt[ADDR_W-1:0] : '0;

  // Memory data lands the cycle after the read strobe, which is the MAU enable cycle.
  assign mau_a      = mau_enable ? rd_data_a : '0;
  assign mau_b      = mau_enable ? rd_data_b : '0;

  assign mau_alu_mode = ALU_PWM;
  assign mau_q        = mau_kd_sel ? DI_Q : KY_Q;
  assign mau_barret_m = mau_kd_sel ? DI_M : KY_M;
  assign mau_mm_N     = mau_kd_sel ? DI_N : KY_N;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      mau_enable <= 1'b0;
      mau_kd_sel <= 1'b0;
    end else begin
      done       <= 1'b0;
      mau_enable <= rd_en & ~abort;
      if (wr_en) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (start && !abort) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            rd_en      <= 1'b1;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            mau_kd_sel <= kd_sel;
          end
        end

        ISSUE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            rd_en <= 1'b0;
          end else if (rd_cnt == CNT_LAST) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end

        DRAIN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (last_write || wr_cnt == CNT_FULL) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          rd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mau_pwm_seq.sv
// Directed bench for mau_pwm_seq: a 256-pair instance with a 3-cycle MAU model and a
// 4-pair instance with a 1-cycle MAU model, both fed from address-derived operand memories.
module tb_mau_pwm_seq;

  localparam int N   = 256;
  localparam int AW  = 8;
  localparam int LAT = 3;
  localparam longint Q_KY = 3329;
  localparam longint Q_DI = 8380417;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, kd_sel = 1'b0, abort = 1'b0;
  logic s_start = 1'b0;
  logic spur_valid = 1'b0;

  always #5 clk = ~clk;

  // ---------------- large instance ----------------
  logic          busy, done, rd_en, mau_enable, mau_kd_sel, mau_valid, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [23:0]   rd_data_a, rd_data_b, mau_a, mau_b, mau_q, mau_o0, wr_data;
  logic [3:0]    mau_alu_mode;
  logic [24:0]   mau_barret_m;
  logic [4:0]    mau_mm_N;

  mau_pwm_seq #(.N_COEF(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kd_sel(kd_sel), .abort(abort),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .mau_a(mau_a), .mau_b(mau_b), .mau_enable(mau_enable),
    .mau_kd_sel(mau_kd_sel), .mau_alu_mode(mau_alu_mode), .mau_q(mau_q),
    .mau_barret_m(mau_barret_m), .mau_mm_N(mau_mm_N),
    .mau_valid(mau_valid), .mau_o0(mau_o0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // ---------------- small instance ----------------
  logic        s_busy, s_done, s_rd_en, s_mau_enable, s_mau_kd_sel, s_mau_valid, s_wr_en;
  logic [1:0]  s_rd_addr, s_wr_addr;
  logic [23:0] s_rd_data_a, s_rd_data_b, s_mau_a, s_mau_b, s_mau_q, s_mau_o0, s_wr_data;
  logic [3:0]  s_mau_alu_mode;
  logic [24:0] s_mau_barret_m;
  logic [4:0]  s_mau_mm_N;

  mau_pwm_seq #(.N_COEF(4), .ADDR_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .kd_sel(1'b0), .abort(1'b0),
    .busy(s_busy), .done(s_done), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b),
    .mau_a(s_mau_a), .mau_b(s_mau_b), .mau_enable(s_mau_enable),
    .mau_kd_sel(s_mau_kd_sel), .mau_alu_mode(s_mau_alu_mode), .mau_q(s_mau_q),
    .mau_barret_m(s_mau_barret_m), .mau_mm_N(s_mau_mm_N),
    .mau_valid(s_mau_valid), .mau_o0(s_mau_o0),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data)
  );

  function automatic logic [23:0] a_of(int k);
    return 24'(k * 32771 + 12345);
  endfunction

  function automatic logic [23:0] b_of(int k);
    return 24'(k * 54321 + 999);
  endfunction

  function automatic logic [23:0] mulmod(logic [23:0] a, logic [23:0] b, logic [23:0] q);
    logic [63:0] p;
    if (q == 24'd0) return 24'd0;
    p = 64'(a) * 64'(b);
    return 24'(p % 64'(q));
  endfunction

  // Operand memories and MAU models
  logic [LAT-1:0] v_pipe = '0;
  logic [23:0]    d_pipe [LAT];
  logic           s_v = 1'b0;
  logic [23:0]    s_d = '0;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= a_of(int'(rd_addr));
      rd_data_b <= b_of(int'(rd_addr));
    end
    v_pipe    <= {v_pipe[LAT-2:0], mau_enable};
    d_pipe[0] <= mulmod(mau_a, mau_b, mau_q);
    for (int i = 1; i < LAT; i++) d_pipe[i] <= d_pipe[i-1];
    if (s_rd_en) begin
      s_rd_data_a <= a_of(int'(s_rd_addr));
      s_rd_data_b <= b_of(int'(s_rd_addr));
    end
    s_v <= s_mau_enable;
    s_d <= mulmod(s_mau_a, s_mau_b, s_mau_q);
  end

  assign mau_valid   = v_pipe[LAT-1] | spur_valid;
  assign mau_o0      = d_pipe[LAT-1];
  assign s_mau_valid = s_v;
  assign s_mau_o0    = s_d;

  // Job monitors; per-job tallies restart when busy rises
  bit job_kd = 1'b0;
  int cyc = 0, total_wr = 0;
  int n_rd, rd_bad, n_wr, wr_bad, data_bad, n_done, done_cyc, last_wr_cyc, cfg_bad;
  int s_n_rd, s_rd_bad, s_n_wr, s_wr_bad, s_data_bad, s_n_done, s_done_cyc, s_last_wr_cyc, s_cfg_bad;
  logic prev_busy = 1'b0, s_prev_busy = 1'b0;

  always @(negedge clk) begin
    logic [23:0] eq;
    logic [24:0] em;
    logic [4:0]  en;
    cyc++;
    eq = job_kd ? 24'(Q_DI) : 24'(Q_KY);
    em = job_kd ? 25'd8396807 : 25'd5039;
    en = job_kd ? 5'd23 : 5'd12;
    if (busy && !prev_busy) begin
      n_rd = 0; rd_bad = 0; n_wr = 0; wr_bad = 0; data_bad = 0;
      n_done = 0; done_cyc = -100; last_wr_cyc = 0; cfg_bad = 0;
    end
    if (rd_en) begin
      if (int'(rd_addr) != n_rd) rd_bad++;
      n_rd++;
    end
    if (wr_en) begin
      if (int'(wr_addr) != n_wr) wr_bad++;
      if (wr_data != mulmod(a_of(n_wr), b_of(n_wr), eq)) data_bad++;
      n_wr++;
      total_wr++;
      last_wr_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy && (mau_q != eq || mau_barret_m != em || mau_mm_N != en ||
                 mau_kd_sel != job_kd || mau_alu_mode != 4'b0100)) cfg_bad++;
    prev_busy = busy;

    if (s_busy && !s_prev_busy) begin
      s_n_rd = 0; s_rd_bad = 0; s_n_wr = 0; s_wr_bad = 0; s_data_bad = 0;
      s_n_done = 0; s_done_cyc = -100; s_last_wr_cyc = 0; s_cfg_bad = 0;
    end
    if (s_rd_en) begin
      if (int'(s_rd_addr) != s_n_rd) s_rd_bad++;
      s_n_rd++;
    end
    if (s_wr_en) begin
      if (int'(s_wr_addr) != s_n_wr) s_wr_bad++;
      if (s_wr_data != mulmod(a_of(s_n_wr), b_of(s_n_wr), 24'(Q_KY))) s_data_bad++;
      s_n_wr++;
      s_last_wr_cyc = cyc;
    end
    if (s_done) begin
      s_n_done++;
      s_done_cyc = cyc;
    end
    if (s_busy && (s_mau_q != 24'd3329 || s_mau_barret_m != 25'd5039 || s_mau_mm_N != 5'd12 ||
                   s_mau_kd_sel || s_mau_alu_mode != 4'b0100)) s_cfg_bad++;
    s_prev_busy = s_busy;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic launch(input bit kd);
    @(negedge clk);
    job_kd = kd;
    kd_sel = kd;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    kd_sel = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic check_job(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_reads"}, n_rd, N);
    chk({tag, "_rd_order"}, rd_bad, 0);
    chk({tag, "_writes"}, n_wr, N);
    chk({tag, "_wr_order"}, wr_bad, 0);
    chk({tag, "_wr_data"}, data_bad, 0);
    chk({tag, "_cfg_stable"}, cfg_bad, 0);
    chk({tag, "_done_count"}, n_done, 1);
    chk({tag, "_done_latency"}, done_cyc - last_wr_cyc, 1);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    bit seen;
    int base;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_mau_enable", mau_enable, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_mau_q", mau_q, Q_KY);
    chk("rst_mau_m", mau_barret_m, 5039);
    chk("rst_mau_n", mau_mm_N, 12);
    chk("rst_alu_mode", mau_alu_mode, 4);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Kyber job
    launch(1'b0);
    chk("ky_busy_after_start", busy, 1);
    chk("ky_first_rd_en", rd_en, 1);
    chk("ky_first_rd_addr", rd_addr, 0);
    wait_done(seen);
    chk("ky_done_seen", seen, 1);
    check_job("ky");

    // Dilithium job with a repeated start mid-job
    launch(1'b1);
    repeat (50) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(seen);
    chk("di_done_seen", seen, 1);
    check_job("di");

    // Abort at read address 100
    launch(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (rd_en && rd_addr == 8'd100) seen = 1'b1;
      else @(negedge clk);
    end
    chk("ab_reached_100", seen, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_rd_en", rd_en, 0);
    chk("ab_busy", busy, 0);
    chk("ab_mau_enable", mau_enable, 0);
    repeat (10) @(negedge clk);
    chk("ab_no_done", n_done, 0);
    chk("ab_writes_partial", n_wr < N, 1);

    // abort and start together while idle
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("ab_start_dropped", busy, 0);
    repeat (3) @(negedge clk);

    launch(1'b0);
    wait_done(seen);
    chk("ab_rerun_done_seen", seen, 1);
    check_job("ab_rerun");

    // Reset asserted mid-job at write 50
    launch(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (wr_en && wr_addr == 8'd50) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rs_reached_50", seen, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_rd_en", rd_en, 0);
    chk("rs_wr_en", wr_en, 0);
    chk("rs_mau_enable", mau_enable, 0);
    chk("rs_wr_addr", wr_addr, 0);
    chk("rs_wr_data", wr_data, 0);
    chk("rs_mau_a", mau_a, 0);
    chk("rs_kd_sel", mau_kd_sel, 0);
    chk("rs_mau_q", mau_q, Q_KY);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = total_wr;
    spur_valid = 1'b1;
    repeat (5) @(negedge clk);
    spur_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rs_spurious_writes", total_wr - base, 0);
    chk("rs_busy_after", busy, 0);

    // Small instance: 4 pairs, MAU latency 1
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (s_done) seen = 1'b1;
    end
    chk("sm_done_seen", seen, 1);
    repeat (4) @(negedge clk);
    chk("sm_reads", s_n_rd, 4);
    chk("sm_rd_order", s_rd_bad, 0);
    chk("sm_writes", s_n_wr, 4);
    chk("sm_wr_order", s_wr_bad, 0);
    chk("sm_wr_data", s_data_bad, 0);
    chk("sm_cfg", s_cfg_bad, 0);
    chk("sm_done_count", s_n_done, 1);
    chk("sm_done_latency", s_done_cyc - s_last_wr_cyc, 1);
    chk("sm_busy_end", s_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mau_pwm_seq.md
MAU_PWM_SEQ -- requirements
Module: mau_pwm_seq

Interface
REQ-001 SHALL have parameter N_COEF, default 256, number of coefficient pairs per job.
REQ-002 SHALL have parameter ADDR_W, default 8, address width (2^ADDR_W >= N_COEF).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  job request pulse.
REQ-006 SHALL have port kd_sel  input  1  0 Kyber, 1 Dilithium; sampled on accepted start.
REQ-007 SHALL have port abort  input  1  synchronous job cancel.
REQ-008 SHALL have port busy  output  1  high from accepted start until done/abort.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rd_en  output  1  operand memory read strobe.
REQ-011 SHALL have port rd_addr  output  ADDR_W  operand read address.
REQ-012 SHALL have ports rd_data_a, rd_data_b  input  24 each  operands, valid one cycle after rd_en.
REQ-013 SHALL have ports mau_a, mau_b  output  24 each  operands to the MAU.
REQ-014 SHALL have port mau_enable  output  1  MAU operand-valid strobe.
REQ-015 SHALL have ports mau_kd_sel 1, mau_alu_mode 4, mau_q 24, mau_barret_m 25, mau_mm_N 5, all output  MAU configuration.
REQ-016 SHALL have ports mau_valid  input  1 and mau_o0  input  24  MAU result handshake.
REQ-017 SHALL have ports wr_en 1, wr_addr ADDR_W, wr_data 24, all output  result write port.

Function
REQ-018 SHALL implement FSM IDLE, ISSUE, DRAIN, DONE.
REQ-019 IDLE: start=1 -> ISSUE, latch kd_sel, clear rd/wr counters, busy=1 next cycle.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 ISSUE: rd_en=1 every cycle, rd_addr = read counter 0..N_COEF-1; after N_COEF-1 issued -> DRAIN.
REQ-022 mau_enable SHALL be rd_en delayed one cycle; mau_a/mau_b = rd_data_a/rd_data_b in that cycle, else 0.
REQ-023 Configuration SHALL be held stable whole job: Kyber q=3329, m=5039, N=12; Dilithium q=8380417, m=8396807, N=23; mau_alu_mode=4'b0100 (PWM).
REQ-024 Each mau_valid=1 while busy SHALL produce wr_en=1 same cycle, wr_data=mau_o0, wr_addr=write counter, then counter+1.
REQ-025 mau_valid while not busy SHALL be ignored (no write).
REQ-026 Results SHALL be accepted in any state while busy, including ISSUE, with arbitrary fixed MAU latency.
REQ-027 DRAIN -> DONE when write counter reaches N_COEF; DONE lasts one cycle, done=1, then IDLE, busy=0.
REQ-028 Counters SHALL be ADDR_W+1 wide; no wrap within a job; N_COEF=2^ADDR_W legal.
REQ-029 abort=1 in any busy state SHALL force IDLE next cycle: rd_en, mau_enable, wr_en deassert, no done pulse.
REQ-030 abort and start in same cycle while IDLE: abort wins, start dropped.
REQ-031 Last write and abort in same cycle: write occurs, done not asserted.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, counters 0, busy=0, done=0, rd_en=0, mau_enable=0, wr_en=0, all data/address outputs 0, mau_kd_sel=0 with Kyber constants.
REQ-033 Reset mid-job SHALL discard the job; first cycle after release is IDLE.

Verification
REQ-034 Kyber job, MAU model latency 3: start, kd_sel=0 -> rd_addr 0..255 contiguous, mau_q=3329, 256 writes wr_addr 0..255 in order, done one cycle after write 255.
REQ-035 Dilithium job: mau_q=8380417, mau_barret_m=8396807, mau_mm_N=23 constant all busy cycles; wr_data equals model a*b mod q.
REQ-036 start repulsed during busy -> no restart, counters unaffected, exactly one done.
REQ-037 abort asserted at rd_addr=100 -> next cycle rd_en=0, busy=0, no done; a new start then runs full 256-write job.
REQ-038 rst_n low at write 50 -> all outputs 0 asynchronously; after release spurious mau_valid produces no wr_en.
REQ-039 N_COEF=4, ADDR_W=2, latency 1 -> exactly 4 writes, addresses 0..3, no counter wrap, done asserted.
